// File: rtl/mmio_host_driver.sv
// Host-side MMIO initiator: one CSR read/write in flight, read responses matched by tid.
// Latency: accept->request pulse 1 cycle, response capture->rd_valid 1 cycle.
// Backpressure: cmd_ready only in IDLE; MMIO_HOST_DRIVER_TIMEOUT_EN adds a read timeout.
module mmio_host_driver #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 16,
    parameter int TID_WIDTH      = 9,
    parameter int WR_GAP         = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  req_rd_valid,
    output logic                  req_wr_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [TID_WIDTH-1:0]  req_tid,
    input  logic                  rsp_valid,
    input  logic [TID_WIDTH-1:0]  rsp_tid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic [15:0]           stale_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT,
        DONE
    } state_t;

    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic                   is_wr;
    logic [TID_WIDTH-1:0]   tid_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   accept;
    logic                   rsp_match;
    logic                   rsp_stale;
    logic                   gap_done;
    logic                   to_hit;

    assign accept   = cmd_valid && cmd_ready;
    assign gap_done = (gap_cnt == GW'(WR_GAP - 1));

    // A response in the same cycle as the read pulse is captured as if already in WAIT.
    assign rsp_match = rsp_valid && (rsp_tid == req_tid) &&
                       ((state == WAIT) || ((state == ISSUE) && !is_wr));
    assign rsp_stale = rsp_valid && !rsp_match;

`ifdef MMIO_HOST_DRIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign to_hit = (state == WAIT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rd_err = (state == DONE) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            if (rsp_match) begin
                err_q <= 1'b0;
            end else if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign to_hit         = 1'b0;
    assign rd_err         = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (is_wr) begin
                    state_nxt = (WR_GAP > 0) ? GAP : IDLE;
                end else if (rsp_match) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (rsp_match || to_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state == IDLE);
    assign req_rd_valid = (state == ISSUE) && !is_wr;
    assign req_wr_valid = (state == ISSUE) && is_wr;
    assign rd_valid     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            tid_cnt   <= '0;
            gap_cnt   <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_tid   <= '0;
            rd_data   <= '0;
            stale_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_wr    <= cmd_wr;
                req_addr <= cmd_addr;
                req_data <= cmd_wdata;
                req_tid  <= tid_cnt;
                // Only reads consume a tid; writes just carry the current one.
                if (!cmd_wr) begin
                    tid_cnt <= tid_cnt + 1'b1;
                end
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (rsp_match) begin
                rd_data <= rsp_data;
            end else if (to_hit) begin
                rd_data <= '1;
            end
            if (rsp_stale && (stale_cnt != 16'hFFFF)) begin
                stale_cnt <= stale_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_host_driver.sv
// Scoreboarded bench for mmio_host_driver: expected requests and read results are queued at stimulus time.
module tb_mmio_host_driver;

    localparam int DW = 64;
    localparam int AW = 16;
    localparam int TW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          req_rd_valid;
    logic          req_wr_valid;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tid;
    logic          rsp_valid;
    logic [TW-1:0] rsp_tid;
    logic [DW-1:0] rsp_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic [15:0]   stale_cnt;

    logic          a_valid = 1'b0;
    logic [TW-1:0] a_tid = '0;
    logic [DW-1:0] a_data = '0;
    logic          m_valid = 1'b0;
    logic [TW-1:0] m_tid = '0;
    logic [DW-1:0] m_data = '0;

    assign rsp_valid = a_valid | m_valid;
    assign rsp_tid   = a_valid ? a_tid : m_tid;
    assign rsp_data  = a_valid ? a_data : m_data;

    always #5 clk = ~clk;

    mmio_host_driver #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW), .WR_GAP(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req_rd_valid(req_rd_valid), .req_wr_valid(req_wr_valid),
        .req_addr(req_addr), .req_data(req_data), .req_tid(req_tid),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .stale_cnt(stale_cnt)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tid;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rd_t;

    req_t          exp_req[$];
    rd_t           exp_rd[$];
    logic [TW-1:0] rsp_q[$];
    req_t          er;
    rd_t           ed;
    int            checks = 0;
    int            errors = 0;
    logic          auto_rsp = 1'b0;
    logic [TW-1:0] model_tid = '0;
    logic [15:0]   exp_stale = '0;
    logic [TW-1:0] late_tid;
    int            rd_seen;
    int            dly;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (req_rd_valid || req_wr_valid)) begin
            if (exp_req.size() == 0) begin
                check("req_unexpected", 1, 0);
            end else begin
                er = exp_req.pop_front();
                check("req_both", req_rd_valid & req_wr_valid, 0);
                check("req_type", req_wr_valid, er.wr);
                check("req_addr", req_addr, er.addr);
                check("req_data", req_data, er.data);
                check("req_tid", req_tid, er.tid);
            end
        end
        if (!rst && rd_valid) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                ed = exp_rd.pop_front();
                check("rd_data", rd_data, ed.data);
                check("rd_err", rd_err, ed.err);
            end
        end
    end

    // Auto responder: answers with the tid the bench expects, 0..3 cycles after the pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_rsp && req_rd_valid && rsp_q.size() > 0) begin
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                a_tid   = rsp_q.pop_front();
                a_data  = {$urandom(), $urandom()};
                a_valid = 1'b1;
                exp_rd.push_back('{a_data, 1'b0});
                @(negedge clk);
                a_valid = 1'b0;
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_wait", 0, 1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        exp_req.push_back('{wr, addr, data, model_tid});
        if (!wr) begin
            if (auto_rsp) rsp_q.push_back(model_tid);
            model_tid++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("req_latency", wr ? req_wr_valid : req_rd_valid, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(cmd_ready && exp_rd.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("done_wait", 0, 1);
        exp_rd.delete();
        rsp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_req_rd", req_rd_valid, 0);
        check("rst_req_wr", req_wr_valid, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_data", req_data, 0);
        check("rst_req_tid", req_tid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_stale", stale_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        do_cmd(1'b1, 16'h0010, 64'hDEADBEEF_CAFEF00D);
        check("wr_ready_low", cmd_ready, 0);
        @(negedge clk);
        check("wr_pulse_end", req_wr_valid, 0);
        check("wr_gap_ready", cmd_ready, 0);
        @(negedge clk);
        check("wr_ready_back", cmd_ready, 1);
        check("wr_addr_hold", req_addr, 16'h0010);
        check("wr_tid", req_tid, 0);

        do_cmd(1'b0, 16'h0020, 64'h0);
        repeat (5) @(negedge clk);
        m_valid = 1'b1;
        m_tid   = 9'd0;
        m_data  = 64'h1234;
        exp_rd.push_back('{64'h1234, 1'b0});
        @(negedge clk);
        m_valid = 1'b0;
        check("rd_pulse", rd_valid, 1);
        @(negedge clk);
        check("rd_pulse_end", rd_valid, 0);
        check("rd_hold", rd_data, 64'h1234);
        wait_done();

        auto_rsp = 1'b1;
        repeat (2) begin
            do_cmd(1'b0, 16'h0030, 64'h0);
            wait_done();
        end

        auto_rsp = 1'b0;
        do_cmd(1'b0, 16'h0040, 64'h0);
        @(negedge clk);
        m_valid = 1'b1;
        m_tid   = 9'd7;
        m_data  = 64'h99;
        exp_stale++;
        @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
        m_valid = 1'b1;
        m_tid   = 9'd3;
        m_data  = 64'h55;
        exp_rd.push_back('{64'h55, 1'b0});
        @(negedge clk);
        m_valid = 1'b0;
        wait_done();
        check("stale_in_wait", stale_cnt, exp_stale);
        check("rd_data_55", rd_data, 64'h55);

        m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        exp_stale++;
        @(negedge clk);
        check("stale_in_idle", stale_cnt, exp_stale);

        auto_rsp = 1'b1;
        for (int i = 0; i < 513; i++) begin
            do_cmd(1'b0, AW'(i), {$urandom(), $urandom()});
            wait_done();
        end
        check("tid_after_wrap", req_tid, 9'd4);

`ifdef MMIO_HOST_DRIVER_TIMEOUT_EN
        auto_rsp = 1'b0;
        late_tid = model_tid;
        do_cmd(1'b0, 16'hF000, 64'h0);
        repeat (16) @(negedge clk);
        check("to_not_early", rd_valid, 0);
        exp_rd.push_back('{{DW{1'b1}}, 1'b1});
        @(negedge clk);
        check("to_valid", rd_valid, 1);
        check("to_err", rd_err, 1);
        check("to_data", rd_data, {DW{1'b1}});
        wait_done();
        m_valid = 1'b1;
        m_tid   = late_tid;
        @(negedge clk);
        m_valid = 1'b0;
        exp_stale++;
        @(negedge clk);
        check("to_late_stale", stale_cnt, exp_stale);
`endif

        auto_rsp = 1'b0;
        do_cmd(1'b0, 16'h0050, 64'h77);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ready", cmd_ready, 1);
        check("arst_req_rd", req_rd_valid, 0);
        check("arst_req_tid", req_tid, 0);
        check("arst_req_addr", req_addr, 0);
        check("arst_req_data", req_data, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_stale", stale_cnt, 0);
        model_tid = '0;
        exp_stale = '0;
        exp_req.delete();
        exp_rd.delete();
        rsp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rd_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_valid) rd_seen++;
        end
        check("no_rd_after_rst", rd_seen, 0);

        auto_rsp = 1'b1;
        do_cmd(1'b0, 16'h0060, 64'h0);
        wait_done();
        check("stale_final", stale_cnt, exp_stale);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
